floo_axi_traffic_monitor: RTL and testbench

FLOO_AXI_TRAFFIC_MONITOR -- requirements
Module: floo_axi_traffic_monitor

---
 rtl/floo_axi_traffic_monitor.sv | 217 +++++++++++++++++++++
 tb/tb_floo_axi_traffic_monitor.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/floo_axi_traffic_monitor.sv
// Windowed AXI W/R beat counter with live outstanding read/write tracking for NumPorts snooped ports.
// Optional macro FLOO_TRAFFIC_MON_OCCUPANCY_EN adds rd_occ_o, the per-window integral of rd_outst.

package floo_axi_mon_pkg;
  // Handshake-level view of an AXI port; wider structs can be substituted as long as these fields exist.
  typedef struct packed {
    logic aw_valid;
    logic w_valid;
    logic b_ready;
    logic ar_valid;
    logic r_ready;
  } axi_req_t;

  typedef struct packed {
    logic aw_ready;
    logic w_ready;
    logic b_valid;
    logic ar_ready;
    logic r_valid;
    logic r_last;
  } axi_rsp_t;
endpackage

module floo_axi_traffic_monitor #(
  parameter int  NumPorts     = 2,
  parameter int  CntWidth     = 32,
  parameter int  WindowCycles = 1024,
  parameter type axi_req_t    = floo_axi_mon_pkg::axi_req_t,
  parameter type axi_rsp_t    = floo_axi_mon_pkg::axi_rsp_t
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               en_i,
  input  logic                               clear_i,
  input  axi_req_t [NumPorts-1:0]            req_i,
  input  axi_rsp_t [NumPorts-1:0]            rsp_i,
  output logic [NumPorts-1:0][CntWidth-1:0]  w_beats_o,
  output logic [NumPorts-1:0][CntWidth-1:0]  r_beats_o,
  output logic [NumPorts-1:0][CntWidth-1:0]  rd_outst_o,
  output logic [NumPorts-1:0][CntWidth-1:0]  wr_outst_o,
`ifdef FLOO_TRAFFIC_MON_OCCUPANCY_EN
  output logic [NumPorts-1:0][CntWidth-1:0]  rd_occ_o,
`endif
  output logic                               window_valid_o,
  output logic                               overflow_o,
  output logic                               error_o
);

  typedef enum logic {StIdle, StRun} state_e;

  localparam int IdxWidth = $clog2(WindowCycles);
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(WindowCycles - 1);
  localparam logic [IdxWidth-1:0] IdxOne  = IdxWidth'(1);
  localparam logic [CntWidth-1:0] CntMax  = '1;
  localparam logic [CntWidth-1:0] CntOne  = CntWidth'(1);

  state_e                            r_state;
  logic [IdxWidth-1:0]               r_idx;
  logic [NumPorts-1:0][CntWidth-1:0] r_wLive, r_rLive, r_wBeats, r_rBeats;
  logic [NumPorts-1:0][CntWidth-1:0] r_rdOutst, r_wrOutst;
  logic                              r_windowValid, r_overflow, r_error;

  logic [NumPorts-1:0][CntWidth-1:0] w_wLiveNext, w_rLiveNext, w_rdOutstNext, w_wrOutstNext;
  logic [NumPorts-1:0]               w_wSat, w_rSat, w_rdErr, w_wrErr;
  logic                              w_lastIdx, w_counting, w_ovfSet, w_errSet;

`ifdef FLOO_TRAFFIC_MON_OCCUPANCY_EN
  logic [NumPorts-1:0][CntWidth-1:0] r_occLive, r_rdOcc, w_occLiveNext;
  logic [NumPorts-1:0]               w_occSat;

  function automatic logic [CntWidth:0] satAdd(input logic [CntWidth-1:0] a,
                                               input logic [CntWidth-1:0] b);
    logic [CntWidth:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[CntWidth]) sum = {1'b1, CntMax};
    return sum;
  endfunction
`endif

  // Returns {saturated, next} for a one-beat increment.
  function automatic logic [CntWidth:0] beatNext(input logic [CntWidth-1:0] cnt, input logic hs);
    logic [CntWidth:0] res;
    res = {1'b0, cnt};
    if (hs) begin
      if (cnt == CntMax) res[CntWidth] = 1'b1;
      else               res = {1'b0, cnt + CntOne};
    end
    return res;
  endfunction

  // Returns {error, next}; simultaneous open and close cancel out.
  function automatic logic [CntWidth:0] outstNext(input logic [CntWidth-1:0] cnt,
                                                  input logic inc, input logic dec);
    logic [CntWidth:0] res;
    res = {1'b0, cnt};
    if (inc && !dec) begin
      if (cnt == CntMax) res[CntWidth] = 1'b1;
      else               res = {1'b0, cnt + CntOne};
    end else if (dec && !inc) begin
      if (cnt == '0) res[CntWidth] = 1'b1;
      else           res = {1'b0, cnt - CntOne};
    end
    return res;
  endfunction

  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      {w_wSat[p], w_wLiveNext[p]} = beatNext(r_wLive[p], req_i[p].w_valid & rsp_i[p].w_ready);
      {w_rSat[p], w_rLiveNext[p]} = beatNext(r_rLive[p], rsp_i[p].r_valid & req_i[p].r_ready);
      {w_rdErr[p], w_rdOutstNext[p]} = outstNext(r_rdOutst[p],
          req_i[p].ar_valid & rsp_i[p].ar_ready,
          rsp_i[p].r_valid & req_i[p].r_ready & rsp_i[p].r_last);
      {w_wrErr[p], w_wrOutstNext[p]} = outstNext(r_wrOutst[p],
          req_i[p].aw_valid & rsp_i[p].aw_ready,
          rsp_i[p].b_valid & req_i[p].b_ready);
`ifdef FLOO_TRAFFIC_MON_OCCUPANCY_EN
      {w_occSat[p], w_occLiveNext[p]} = satAdd(r_occLive[p], r_rdOutst[p]);
`endif
    end
  end

  assign w_lastIdx  = (r_idx == LastIdx);
  assign w_counting = (r_state == StRun) & en_i;
  assign w_errSet   = (|w_rdErr) | (|w_wrErr);
`ifdef FLOO_TRAFFIC_MON_OCCUPANCY_EN
  assign w_ovfSet   = w_counting & ((|w_wSat) | (|w_rSat) | (|w_occSat));
`else
  assign w_ovfSet   = w_counting & ((|w_wSat) | (|w_rSat));
`endif

  // A latch at the window end is assigned after the clear, so it takes priority.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= StIdle;
      r_idx         <= '0;
      r_wLive       <= '0;
      r_rLive       <= '0;
      r_wBeats      <= '0;
      r_rBeats      <= '0;
      r_rdOutst     <= '0;
      r_wrOutst     <= '0;
      r_windowValid <= 1'b0;
      r_overflow    <= 1'b0;
      r_error       <= 1'b0;
`ifdef FLOO_TRAFFIC_MON_OCCUPANCY_EN
      r_occLive     <= '0;
      r_rdOcc       <= '0;
`endif
    end else begin
      r_rdOutst     <= w_rdOutstNext;
      r_wrOutst     <= w_wrOutstNext;
      r_windowValid <= 1'b0;
      r_overflow    <= ~clear_i & (r_overflow | w_ovfSet);
      r_error       <= ~clear_i & (r_error | w_errSet);
      if (clear_i) begin
        r_wBeats <= '0;
        r_rBeats <= '0;
`ifdef FLOO_TRAFFIC_MON_OCCUPANCY_EN
        r_rdOcc  <= '0;
`endif
      end
      case (r_state)
        StIdle: begin
          r_idx   <= '0;
          r_wLive <= '0;
          r_rLive <= '0;
`ifdef FLOO_TRAFFIC_MON_OCCUPANCY_EN
          r_occLive <= '0;
`endif
          if (en_i) r_state <= StRun;
        end
        StRun: begin
          if (!en_i) begin
            r_state <= StIdle;
            r_idx   <= '0;
            r_wLive <= '0;
            r_rLive <= '0;
`ifdef FLOO_TRAFFIC_MON_OCCUPANCY_EN
            r_occLive <= '0;
`endif
          end else if (w_lastIdx) begin
            r_wBeats      <= w_wLiveNext;
            r_rBeats      <= w_rLiveNext;
            r_wLive       <= '0;
            r_rLive       <= '0;
            r_idx         <= '0;
            r_windowValid <= 1'b1;
`ifdef FLOO_TRAFFIC_MON_OCCUPANCY_EN
            r_rdOcc   <= w_occLiveNext;
            r_occLive <= '0;
`endif
          end else begin
            r_wLive <= w_wLiveNext;
            r_rLive <= w_rLiveNext;
            r_idx   <= r_idx + IdxOne;
`ifdef FLOO_TRAFFIC_MON_OCCUPANCY_EN
            r_occLive <= w_occLiveNext;
`endif
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign w_beats_o      = r_wBeats;
  assign r_beats_o      = r_rBeats;
  assign rd_outst_o     = r_rdOutst;
  assign wr_outst_o     = r_wrOutst;
  assign window_valid_o = r_windowValid;
  assign overflow_o     = r_overflow;
  assign error_o        = r_error;
`ifdef FLOO_TRAFFIC_MON_OCCUPANCY_EN
  assign rd_occ_o       = r_rdOcc;
`endif

endmodule

// File: tb/tb_floo_axi_traffic_monitor.sv
// Bench for floo_axi_traffic_monitor: two instances (A: 8-bit/16-cycle, B: 4-bit/24-cycle) on shared
// stimulus, compared every cycle against a count-based behavioural model, plus directed literal checks.

module tb_floo_axi_traffic_monitor;
  import floo_axi_mon_pkg::*;

  localparam int NP = 2;

  logic clk = 1'b0;
  logic rst, en, clear;
  axi_req_t [NP-1:0] req;
  axi_rsp_t [NP-1:0] rsp;

  logic [NP-1:0][7:0] aW, aR, aRd, aWr;
  logic [NP-1:0][3:0] bW, bR, bRd, bWr;
  logic aValid, aOvf, aErr, bValid, bOvf, bErr;
`ifdef FLOO_TRAFFIC_MON_OCCUPANCY_EN
  logic [NP-1:0][7:0] aOcc;
  logic [NP-1:0][3:0] bOcc;
`endif

  int nCompared   = 0;
  int nMismatched = 0;

  // Model state: live counts are unbounded; outputs are what the DUT must show after each edge.
  int mRun[2], mIdx[2], mW[2][NP], mR[2][NP];
  int oW[2][NP], oR[2][NP], oRd[2][NP], oWr[2][NP], oValid[2], oOvf[2], oErr[2];
`ifdef FLOO_TRAFFIC_MON_OCCUPANCY_EN
  int mOcc[2][NP], oOcc[2][NP];
`endif

  int arSeq[7]  = '{1, 1, 1, 1, 0, 0, 0};
  int rlSeq[7]  = '{0, 0, 0, 1, 1, 1, 1};
  int expRd[7]  = '{1, 2, 3, 3, 2, 1, 0};

  always #5 clk = ~clk;

  floo_axi_traffic_monitor #(.NumPorts(NP), .CntWidth(8), .WindowCycles(16)) dutA (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clear_i(clear), .req_i(req), .rsp_i(rsp),
    .w_beats_o(aW), .r_beats_o(aR), .rd_outst_o(aRd), .wr_outst_o(aWr),
`ifdef FLOO_TRAFFIC_MON_OCCUPANCY_EN
    .rd_occ_o(aOcc),
`endif
    .window_valid_o(aValid), .overflow_o(aOvf), .error_o(aErr)
  );

  floo_axi_traffic_monitor #(.NumPorts(NP), .CntWidth(4), .WindowCycles(24)) dutB (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clear_i(clear), .req_i(req), .rsp_i(rsp),
    .w_beats_o(bW), .r_beats_o(bR), .rd_outst_o(bRd), .wr_outst_o(bWr),
`ifdef FLOO_TRAFFIC_MON_OCCUPANCY_EN
    .rd_occ_o(bOcc),
`endif
    .window_valid_o(bValid), .overflow_o(bOvf), .error_o(bErr)
  );

  function automatic int winOf(input int k);
    return (k == 0) ? 16 : 24;
  endfunction

  function automatic int maxOf(input int k);
    return (k == 0) ? 255 : 15;
  endfunction

  function automatic int minOf(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int outstStep(input int cnt, input bit inc, input bit dec, input int mx,
                                   output bit err);
    int res;
    res = cnt;
    err = 1'b0;
    if (inc && !dec) begin
      if (cnt >= mx) err = 1'b1;
      else res = cnt + 1;
    end else if (dec && !inc) begin
      if (cnt <= 0) err = 1'b1;
      else res = cnt - 1;
    end
    return res;
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    nCompared++;
    if (actual != expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Advance the model by one rising edge using the inputs currently on the bus.
  task automatic stepModel();
    for (int k = 0; k < 2; k++) begin
      int  mx;
      bit  ovfSet, errSet, latched, e;
      int  oldRd[NP];
      if (rst) begin
        mRun[k] = 0; mIdx[k] = 0; oValid[k] = 0; oOvf[k] = 0; oErr[k] = 0;
        for (int p = 0; p < NP; p++) begin
          mW[k][p] = 0; mR[k][p] = 0; oW[k][p] = 0; oR[k][p] = 0; oRd[k][p] = 0; oWr[k][p] = 0;
`ifdef FLOO_TRAFFIC_MON_OCCUPANCY_EN
          mOcc[k][p] = 0; oOcc[k][p] = 0;
`endif
        end
      end else begin
        mx = maxOf(k); ovfSet = 0; errSet = 0; latched = 0;
        for (int p = 0; p < NP; p++) begin
          oldRd[p] = oRd[k][p];
          oRd[k][p] = outstStep(oRd[k][p], req[p].ar_valid && rsp[p].ar_ready,
                                rsp[p].r_valid && req[p].r_ready && rsp[p].r_last, mx, e);
          errSet |= e;
          oWr[k][p] = outstStep(oWr[k][p], req[p].aw_valid && rsp[p].aw_ready,
                                rsp[p].b_valid && req[p].b_ready, mx, e);
          errSet |= e;
        end
        if (mRun[k] != 0) begin
          if (!en) begin
            mRun[k] = 0; mIdx[k] = 0;
            for (int p = 0; p < NP; p++) begin
              mW[k][p] = 0; mR[k][p] = 0;
`ifdef FLOO_TRAFFIC_MON_OCCUPANCY_EN
              mOcc[k][p] = 0;
`endif
            end
          end else begin
            for (int p = 0; p < NP; p++) begin
              if (req[p].w_valid && rsp[p].w_ready) begin
                mW[k][p]++;
                if (mW[k][p] > mx) ovfSet = 1;
              end
              if (rsp[p].r_valid && req[p].r_ready) begin
                mR[k][p]++;
                if (mR[k][p] > mx) ovfSet = 1;
              end
`ifdef FLOO_TRAFFIC_MON_OCCUPANCY_EN
              if (oldRd[p] > 0) begin
                mOcc[k][p] += oldRd[p];
                if (mOcc[k][p] > mx) ovfSet = 1;
              end
`endif
            end
            if (mIdx[k] == winOf(k) - 1) begin
              latched = 1; mIdx[k] = 0;
              for (int p = 0; p < NP; p++) begin
                oW[k][p] = minOf(mW[k][p], mx); oR[k][p] = minOf(mR[k][p], mx);
                mW[k][p] = 0; mR[k][p] = 0;
`ifdef FLOO_TRAFFIC_MON_OCCUPANCY_EN
                oOcc[k][p] = minOf(mOcc[k][p], mx); mOcc[k][p] = 0;
`endif
              end
            end else begin
              mIdx[k]++;
            end
          end
        end else if (en) begin
          mRun[k] = 1; mIdx[k] = 0;
        end
        if (clear) begin
          if (!latched) begin
            for (int p = 0; p < NP; p++) begin
              oW[k][p] = 0; oR[k][p] = 0;
`ifdef FLOO_TRAFFIC_MON_OCCUPANCY_EN
              oOcc[k][p] = 0;
`endif
            end
          end
          oOvf[k] = 0; oErr[k] = 0;
        end else begin
          if (ovfSet) oOvf[k] = 1;
          if (errSet) oErr[k] = 1;
        end
        oValid[k] = latched ? 1 : 0;
      end
    end
  endtask

  task automatic compareAll();
    checkOutput("A.window_valid", aValid, oValid[0]);
    checkOutput("A.overflow", aOvf, oOvf[0]);
    checkOutput("A.error", aErr, oErr[0]);
    checkOutput("B.window_valid", bValid, oValid[1]);
    checkOutput("B.overflow", bOvf, oOvf[1]);
    checkOutput("B.error", bErr, oErr[1]);
    for (int p = 0; p < NP; p++) begin
      checkOutput($sformatf("A.w_beats[%0d]", p), aW[p], oW[0][p]);
      checkOutput($sformatf("A.r_beats[%0d]", p), aR[p], oR[0][p]);
      checkOutput($sformatf("A.rd_outst[%0d]", p), aRd[p], oRd[0][p]);
      checkOutput($sformatf("A.wr_outst[%0d]", p), aWr[p], oWr[0][p]);
      checkOutput($sformatf("B.w_beats[%0d]", p), bW[p], oW[1][p]);
      checkOutput($sformatf("B.r_beats[%0d]", p), bR[p], oR[1][p]);
      checkOutput($sformatf("B.rd_outst[%0d]", p), bRd[p], oRd[1][p]);
      checkOutput($sformatf("B.wr_outst[%0d]", p), bWr[p], oWr[1][p]);
`ifdef FLOO_TRAFFIC_MON_OCCUPANCY_EN
      checkOutput($sformatf("A.rd_occ[%0d]", p), aOcc[p], oOcc[0][p]);
      checkOutput($sformatf("B.rd_occ[%0d]", p), bOcc[p], oOcc[1][p]);
`endif
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      stepModel();
      #1;
      compareAll();
    end
  end

  task automatic idleBus();
    req = '0;
    rsp = '0;
  endtask

  task automatic setW0(input bit b);
    req[0].w_valid = b;
    rsp[0].w_ready = b;
  endtask

  task automatic doReset();
    rst = 1'b1; en = 1'b0; clear = 1'b0;
    idleBus();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One random bus cycle; density controls how busy every channel is.
  task automatic applyStimulus(input int dens);
    for (int p = 0; p < NP; p++) begin
      req[p].aw_valid = ($urandom_range(0, 99) < dens);
      rsp[p].aw_ready = ($urandom_range(0, 99) < dens);
      req[p].w_valid  = ($urandom_range(0, 99) < dens);
      rsp[p].w_ready  = ($urandom_range(0, 99) < dens);
      rsp[p].b_valid  = ($urandom_range(0, 99) < dens);
      req[p].b_ready  = ($urandom_range(0, 99) < dens);
      req[p].ar_valid = ($urandom_range(0, 99) < dens);
      rsp[p].ar_ready = ($urandom_range(0, 99) < dens);
      rsp[p].r_valid  = ($urandom_range(0, 99) < dens);
      req[p].r_ready  = ($urandom_range(0, 99) < dens);
      rsp[p].r_last   = ($urandom_range(0, 1) == 1);
    end
    if ($urandom_range(0, 59) == 0) en = ~en;
    clear = ($urandom_range(0, 79) == 0);
    rst   = ($urandom_range(0, 999) == 0);
    @(negedge clk);
  endtask

  initial begin
    int cyc, pulses, dens;
    doReset();
    checkOutput("reset.A.valid", aValid, 0);
    checkOutput("reset.A.w_beats0", aW[0], 0);
    checkOutput("reset.B.rd_outst0", bRd[0], 0);

    // Continuous W beats on port 0 from the cycle en rises.
    setW0(1'b1); en = 1'b1; cyc = 0; pulses = 0;
    while (pulses == 0 && cyc < 40) begin
      @(negedge clk); cyc++;
      if (aValid) pulses = 1;
    end
    checkOutput("r036.pulse_cycle", cyc, 17);
    checkOutput("r036.w_beats0", aW[0], 16);
    checkOutput("r036.overflow", aOvf, 0);
    checkOutput("r036.model_w_beats0", oW[0][0], 16);
    @(negedge clk);
    checkOutput("r036.pulse_width", aValid, 0);

    // Twenty R beats into the 4-bit instance saturate at 15.
    doReset();
    rsp[0].r_valid = 1'b1; req[0].r_ready = 1'b1; en = 1'b1;
    repeat (21) @(negedge clk);
    idleBus(); cyc = 0;
    while (!bValid && cyc < 60) begin @(negedge clk); cyc++; end
    checkOutput("r037.r_beats0", bR[0], 15);
    checkOutput("r037.overflow", bOvf, 1);
    checkOutput("r037.model_r_beats0", oR[1][0], 15);
    clear = 1'b1; @(negedge clk); clear = 1'b0;
    checkOutput("r037.cleared_r_beats0", bR[0], 0);
    checkOutput("r037.cleared_overflow", bOvf, 0);
    en = 1'b0;

    // Read outstanding sequence, including a cancelling AR + R-last cycle.
    doReset();
    for (int i = 0; i < 7; i++) begin
      req[0].ar_valid = arSeq[i][0]; rsp[0].ar_ready = arSeq[i][0];
      rsp[0].r_valid = rlSeq[i][0]; req[0].r_ready = rlSeq[i][0]; rsp[0].r_last = rlSeq[i][0];
      @(negedge clk);
      checkOutput($sformatf("r038.rd_outst_step%0d", i), aRd[0], expRd[i]);
    end
    idleBus();
    checkOutput("r038.error", aErr, 0);

    // B handshake with nothing outstanding.
    rsp[0].b_valid = 1'b1; req[0].b_ready = 1'b1;
    @(negedge clk); idleBus();
    checkOutput("r039.wr_outst0", aWr[0], 0);
    checkOutput("r039.error", aErr, 1);
    repeat (3) @(negedge clk);
    checkOutput("r039.error_sticky", aErr, 1);
    clear = 1'b1; @(negedge clk); clear = 1'b0;
    checkOutput("r039.error_cleared", aErr, 0);

    // Window aborted mid-way keeps the previous result and emits no pulse.
    doReset();
    en = 1'b1; @(negedge clk);
    for (int i = 0; i < 16; i++) begin setW0(i < 10); @(negedge clk); end
    setW0(1'b0);
    checkOutput("r040.first_pulse", aValid, 1);
    checkOutput("r040.first_w_beats0", aW[0], 10);
    for (int i = 0; i < 8; i++) begin setW0(i < 5); @(negedge clk); end
    setW0(1'b0); en = 1'b0; pulses = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (aValid) pulses++; end
    checkOutput("r040.no_pulse", pulses, 0);
    checkOutput("r040.held_w_beats0", aW[0], 10);
    en = 1'b1; @(negedge clk);
    for (int i = 0; i < 16; i++) begin setW0(i < 3); @(negedge clk); end
    setW0(1'b0);
    checkOutput("r040.second_pulse", aValid, 1);
    checkOutput("r040.second_w_beats0", aW[0], 3);
    en = 1'b0;

`ifdef FLOO_TRAFFIC_MON_OCCUPANCY_EN
    // Two reads held open across a whole window.
    doReset();
    req[0].ar_valid = 1'b1; rsp[0].ar_ready = 1'b1;
    repeat (2) @(negedge clk);
    idleBus(); en = 1'b1; cyc = 0;
    while (!aValid && cyc < 40) begin @(negedge clk); cyc++; end
    checkOutput("r041.rd_occ0", aOcc[0], 32);
    en = 1'b0;
`endif

    // Randomised traffic in phases of varying density.
    doReset();
    en = 1'b1;
    for (int ph = 0; ph < 20; ph++) begin
      case ($urandom_range(0, 2))
        0:       dens = 15;
        1:       dens = 55;
        default: dens = 97;
      endcase
      for (int c = 0; c < 200; c++) applyStimulus(dens);
    end
    rst = 1'b0; clear = 1'b0; en = 1'b0; idleBus();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
